// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds BCD digits from a multiplexed active-low 7-segment bus, filters for
// stability, flags illegal patterns and hands out one frame per scan (valid/ready).
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              segments,
    input  logic [NUM_DIGITS-1:0]   anodes,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    overrun,
    output logic                    bus_fault
);

    localparam int          SW        = NUM_DIGITS + 8;
    localparam logic [7:0]  STABLE    = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] FULL_MASK = '1;

    typedef enum logic {EMPTY, FULL} state_t;

    // Returns {err, nibble}; dp is not part of the pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h40:   decode_seg = 5'h00;
            7'h79:   decode_seg = 5'h01;
            7'h24:   decode_seg = 5'h02;
            7'h30:   decode_seg = 5'h03;
            7'h19:   decode_seg = 5'h04;
            7'h12:   decode_seg = 5'h05;
            7'h02:   decode_seg = 5'h06;
            7'h78:   decode_seg = 5'h07;
            7'h00:   decode_seg = 5'h08;
            7'h10:   decode_seg = 5'h09;
            default: decode_seg = 5'h1F;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [SW-1:0]           sample_q, sample_d, prev_q, prev_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d, bcd_out_q, bcd_out_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d, digit_err_q, digit_err_d;
    logic                    overrun_q, overrun_d, bus_fault_q, bus_fault_d;

    logic [3:0]              low_cnt;
    logic [NUM_DIGITS-1:0]   cap_bits;
    logic                    legal, multi, capture, frame_done, load, drop;
    logic [4:0]              dec;

    // Anode analysis and stability counter on the registered sample
    always_comb begin
        sample_d = {anodes, segments};
        prev_d   = sample_q;
        low_cnt  = '0;
        cap_bits = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sample_q[8+i]) begin
                low_cnt     = low_cnt + 4'd1;
                cap_bits[i] = 1'b1;
            end
        end
        legal = (low_cnt == 4'd1);
        multi = (low_cnt > 4'd1);

        if (sample_q != prev_q)
            cnt_d = legal ? 8'd1 : 8'd0;
        else if (!legal)
            cnt_d = 8'd0;
        else if (cnt_q < STABLE)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = cnt_q;

        capture = legal && (cnt_d == STABLE) && (cnt_q != STABLE);
        dec     = decode_seg(sample_q[6:0]);
    end

    // Shadow digits and frame assembly
    always_comb begin
        shadow_bcd_d = shadow_bcd_q;
        shadow_err_d = shadow_err_q;
        mask_d       = mask_q;
        frame_done   = 1'b0;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_bits[i]) begin
                    shadow_bcd_d[i*4 +: 4] = dec[3:0];
                    shadow_err_d[i]        = dec[4];
                end
            end
            mask_d = mask_q | cap_bits;
            if (mask_d == FULL_MASK) begin
                frame_done = 1'b1;
                mask_d     = '0;
            end
        end

        load        = frame_done && ((state_q == EMPTY) || out_ready);
        drop        = frame_done && (state_q == FULL) && !out_ready;
        bcd_out_d   = load ? shadow_bcd_d : bcd_out_q;
        digit_err_d = load ? shadow_err_d : digit_err_q;
        overrun_d   = overrun_q | drop;
        bus_fault_d = bus_fault_q | multi;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (frame_done) state_d = FULL;
            FULL:    if (!frame_done && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
    end

    // Sample resets to a blank bus so the first post-reset cycle is not seen as multi-low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            sample_q     <= '1;
            prev_q       <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            shadow_bcd_q <= '0;
            shadow_err_q <= '0;
            bcd_out_q    <= '0;
            digit_err_q  <= '0;
            overrun_q    <= 1'b0;
            bus_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_err_q <= shadow_err_d;
            bcd_out_q    <= bcd_out_d;
            digit_err_q  <= digit_err_d;
            overrun_q    <= overrun_d;
            bus_fault_q  <= bus_fault_d;
        end
    end

    assign bcd_out   = bcd_out_q;
    assign digit_err = digit_err_q;
    assign overrun   = overrun_q;
    assign bus_fault = bus_fault_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with NUM_DIGITS=4, STABLE_CYCLES=8.
module tb_seven_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  segments;
    logic [3:0]  anodes;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        overrun;
    logic        bus_fault;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int vbase  = 0;
    logic [15:0] last_bcd = '0;
    logic [3:0]  last_err = '0;

    seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .segments  (segments),
        .anodes    (anodes),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .digit_err (digit_err),
        .overrun   (overrun),
        .bus_fault (bus_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            vcount   <= vcount + 1;
            last_bcd <= bcd_out;
            last_err <= digit_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1
    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        anodes   = an;
        segments = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [7:0] s0, s1, s2, s3);
        hold(4'b1110, s0, 20);
        hold(4'b1101, s1, 20);
        hold(4'b1011, s2, 20);
        hold(4'b0111, s3, 20);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        anodes   = 4'hF;
        segments = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; anodes = 4'hF; segments = 8'hFF; out_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();
        check("rst_valid",   32'(out_valid), 32'h0);
        check("rst_bcd",     32'(bcd_out),   32'h0);
        check("rst_err",     32'(digit_err), 32'h0);
        check("rst_overrun", 32'(overrun),   32'h0);
        check("rst_fault",   32'(bus_fault), 32'h0);

        // Normal scan, consumer always ready
        vbase = vcount;
        hold(4'b1110, 8'hC0, 20);
        hold(4'b1101, 8'hF9, 20);
        hold(4'b1011, 8'hA4, 20);
        check("scan_partial_nofr", 32'(vcount - vbase), 32'd0);
        hold(4'b0111, 8'hB0, 20);
        check("scan_pulses",  32'(vcount - vbase), 32'd1);
        check("scan_bcd",     32'(last_bcd), 32'h3210);
        check("scan_err",     32'(last_err), 32'h0);
        check("scan_valid_end", 32'(out_valid), 32'h0);
        check("scan_overrun", 32'(overrun), 32'h0);

        // Glitching digit 0 never settles, so digits 1..3 cannot complete a frame
        do_reset();
        vbase = vcount;
        repeat (4) begin
            hold(4'b1110, 8'hC0, 6);
            hold(4'b1110, 8'h80, 6);
        end
        hold(4'b1101, 8'hF9, 20);
        hold(4'b1011, 8'hA4, 20);
        hold(4'b0111, 8'hB0, 20);
        check("glitch_nofr",  32'(vcount - vbase), 32'd0);
        check("glitch_valid", 32'(out_valid), 32'h0);

        // Illegal pattern on digit 2, dp-low 9 on digit 0
        do_reset();
        vbase = vcount;
        scan(8'h10, 8'h80, 8'h7F, 8'hF8);
        check("illegal_pulses", 32'(vcount - vbase), 32'd1);
        check("illegal_bcd",    32'(last_bcd), 32'h7F89);
        check("illegal_err",    32'(last_err), 32'h4);

        // Backpressure: second frame dropped
        do_reset();
        out_ready = 1'b0;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        check("bp_valid1",   32'(out_valid), 32'h1);
        check("bp_bcd1",     32'(bcd_out),   32'h3210);
        check("bp_overrun0", 32'(overrun),   32'h0);
        scan(8'h92, 8'h82, 8'hF8, 8'h80);
        check("bp_bcd_held", 32'(bcd_out),   32'h3210);
        check("bp_err_held", 32'(digit_err), 32'h0);
        check("bp_overrun1", 32'(overrun),   32'h1);
        hold(4'hF, 8'hFF, 2);
        out_ready = 1'b1;
        #3;
        check("bp_valid_before_edge", 32'(out_valid), 32'h1);
        @(posedge clk); #1;
        check("bp_valid_dropped", 32'(out_valid), 32'h0);
        check("bp_overrun_sticky", 32'(overrun), 32'h1);

        // Accept coincides with frame-complete: reload, stay full
        do_reset();
        out_ready = 1'b0;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        hold(4'b1110, 8'h92, 20);
        hold(4'b1101, 8'h82, 20);
        hold(4'b1011, 8'hF8, 20);
        hold(4'b0111, 8'h80, 8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("sim_valid",   32'(out_valid), 32'h1);
        check("sim_bcd",     32'(bcd_out),   32'h8765);
        check("sim_overrun", 32'(overrun),   32'h0);
        hold(4'b0111, 8'h80, 11);
        hold(4'hF, 8'hFF, 2);
        check("sim_valid_held", 32'(out_valid), 32'h1);

        // Bus fault, then reset mid-frame
        do_reset();
        out_ready = 1'b0;
        vbase = vcount;
        hold(4'b1100, 8'hC0, 3);
        check("fault_flag", 32'(bus_fault), 32'h1);
        hold(4'b1100, 8'hC0, 17);
        hold(4'b1101, 8'hF9, 20);
        hold(4'b1011, 8'hA4, 20);
        hold(4'b0111, 8'hB0, 20);
        check("fault_nocap", 32'(vcount - vbase), 32'd0);
        hold(4'b1110, 8'hC0, 20);
        check("fault_frame_valid", 32'(out_valid), 32'h1);
        check("fault_frame_bcd",   32'(bcd_out),   32'h3210);
        hold(4'b1110, 8'h99, 20);
        hold(4'b1101, 8'h92, 20);
        hold(4'b1011, 8'h82, 15);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_bcd",   32'(bcd_out),   32'h0);
        check("mid_rst_err",   32'(digit_err), 32'h0);
        check("mid_rst_ovr",   32'(overrun),   32'h0);
        check("mid_rst_fault", 32'(bus_fault), 32'h0);
        anodes = 4'hF; segments = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b0111, 8'hF8, 20);
        check("post_rst_partial", 32'(out_valid), 32'h0);
        hold(4'b1110, 8'h99, 20);
        hold(4'b1101, 8'h92, 20);
        hold(4'b1011, 8'h82, 20);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_bcd",   32'(bcd_out),   32'h7654);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
